// File: rtl/character_move_scheduler_pkg.sv
// Shared constants for the character move scheduler: maze size, direction codes,
// FSM state codes and spawn tiles.
package character_move_scheduler_pkg;

    localparam int unsigned DEF_TILE_COLS = 28;
    localparam int unsigned DEF_TILE_ROWS = 31;
    localparam int unsigned DEF_COL_W     = 5;
    localparam int unsigned DEF_ROW_W     = 5;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_COLLIDE = 2'd3;

    localparam int unsigned NUM_GHOSTS       = 4;
    localparam int unsigned PLAYER_SPAWN_COL = 13;
    localparam int unsigned PLAYER_SPAWN_ROW = 23;
    localparam int unsigned GHOST_SPAWN_COL [4] = '{13, 11, 13, 15};
    localparam int unsigned GHOST_SPAWN_ROW [4] = '{11, 14, 14, 14};

endpackage

// File: rtl/character_move_scheduler_tile_step_calc.sv
// Combinational one-tile step: horizontal moves wrap through the tunnel, vertical
// moves off the maze edge are flagged out of bounds and leave the tile unchanged.
module tile_step_calc
    import character_move_scheduler_pkg::*;
#(
    parameter int unsigned TILE_COLS = DEF_TILE_COLS,
    parameter int unsigned TILE_ROWS = DEF_TILE_ROWS,
    parameter int unsigned COL_W     = DEF_COL_W,
    parameter int unsigned ROW_W     = DEF_ROW_W
) (
    input  logic [COL_W-1:0] col_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [1:0]       dir_i,
    output logic [COL_W-1:0] next_col_o,
    output logic [ROW_W-1:0] next_row_o,
    output logic             oob_o
);

    localparam logic [COL_W-1:0] LastCol = COL_W'(TILE_COLS - 1);
    localparam logic [ROW_W-1:0] LastRow = ROW_W'(TILE_ROWS - 1);

    always_comb begin
        next_col_o = col_i;
        next_row_o = row_i;
        oob_o      = 1'b0;
        unique case (dir_i)
            DIR_UP: begin
                if (row_i == '0) oob_o = 1'b1;
                else             next_row_o = row_i - 1'b1;
            end
            DIR_LEFT: next_col_o = (col_i == '0) ? LastCol : col_i - 1'b1;
            DIR_DOWN: begin
                if (row_i == LastRow) oob_o = 1'b1;
                else                  next_row_o = row_i + 1'b1;
            end
            default: next_col_o = (col_i == LastCol) ? '0 : col_i + 1'b1;
        endcase
    end

endmodule

// File: rtl/character_move_scheduler.sv
// Per-tick movement sweep for player and four ghosts over one shared wall-map read port,
// with buffered player turns, tunnel wrap and end-of-sweep collision detection.
module character_move_scheduler
    import character_move_scheduler_pkg::*;
#(
    parameter int unsigned TILE_COLS = DEF_TILE_COLS,
    parameter int unsigned TILE_ROWS = DEF_TILE_ROWS,
    parameter int unsigned COL_W     = DEF_COL_W,
    parameter int unsigned ROW_W     = DEF_ROW_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               step_i,
    input  logic               enable_i,
    input  logic               player_req_valid_i,
    input  logic [1:0]         player_req_dir_i,
    input  logic [7:0]         ghost_dir_i,
    output logic               wall_rd_o,
    output logic [COL_W-1:0]   wall_col_o,
    output logic [ROW_W-1:0]   wall_row_o,
    input  logic               wall_is_wall_i,
    output logic [COL_W-1:0]   player_col_o,
    output logic [ROW_W-1:0]   player_row_o,
    output logic [1:0]         player_dir_o,
    output logic [4*COL_W-1:0] ghost_col_o,
    output logic [4*ROW_W-1:0] ghost_row_o,
    output logic [3:0]         ghost_blocked_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               collision_o,
    output logic               overrun_o
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             retry_q, retry_d;
    logic [1:0]       try_dir_q, try_dir_d;
    logic [COL_W-1:0] tgt_col_q, tgt_col_d;
    logic [ROW_W-1:0] tgt_row_q, tgt_row_d;
    logic             oob_q, oob_d;
    logic             wall_rd_q, wall_rd_d;
    logic [COL_W-1:0] player_col_q, player_col_d;
    logic [ROW_W-1:0] player_row_q, player_row_d;
    logic [1:0]       player_dir_q, player_dir_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_dir_q, pend_dir_d;
    logic [COL_W-1:0] ghost_col_q [4];
    logic [COL_W-1:0] ghost_col_d [4];
    logic [ROW_W-1:0] ghost_row_q [4];
    logic [ROW_W-1:0] ghost_row_d [4];
    logic [1:0]       ghost_dir_q [4];
    logic [1:0]       ghost_dir_d [4];
    logic [3:0]       ghost_blocked_q, ghost_blocked_d;
    logic             done_q, done_d;
    logic             collision_q, collision_d;

    logic             blocked, load, sel_retry;
    logic [2:0]       sel_idx;
    logic [1:0]       sel_dir, sel_gi, cur_gi;
    logic [COL_W-1:0] sel_col, calc_col;
    logic [ROW_W-1:0] sel_row, calc_row;
    logic             calc_oob;

    // done_q keeps busy high through the done cycle so a step there counts as overrun.
    assign busy_o    = (state_q != ST_IDLE) || done_q;
    assign overrun_o = step_i && busy_o;
    assign blocked   = oob_q || wall_is_wall_i;
    assign cur_gi    = 2'(idx_q - 3'd1);

    // Decide whether a new lookup is issued this cycle, and for whom.
    always_comb begin
        load      = 1'b0;
        sel_idx   = 3'd0;
        sel_dir   = player_dir_q;
        sel_retry = 1'b0;
        if (state_q == ST_IDLE) begin
            if (step_i && enable_i && !busy_o) begin
                load    = 1'b1;
                sel_dir = pend_valid_q ? pend_dir_q : player_dir_q;
            end
        end else if (state_q == ST_CHECK) begin
            if (idx_q == 3'd0 && !retry_q && blocked && try_dir_q != player_dir_q) begin
                load      = 1'b1;
                sel_retry = 1'b1;
            end else if (idx_q != 3'd4) begin
                load    = 1'b1;
                sel_idx = idx_q + 3'd1;
                sel_dir = ghost_dir_i[{idx_q[1:0], 1'b0} +: 2];
            end
        end
    end

    assign sel_gi  = 2'(sel_idx - 3'd1);
    assign sel_col = (sel_idx == 3'd0) ? player_col_q : ghost_col_q[sel_gi];
    assign sel_row = (sel_idx == 3'd0) ? player_row_q : ghost_row_q[sel_gi];

    tile_step_calc #(
        .TILE_COLS (TILE_COLS),
        .TILE_ROWS (TILE_ROWS),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_step (
        .col_i      (sel_col),
        .row_i      (sel_row),
        .dir_i      (sel_dir),
        .next_col_o (calc_col),
        .next_row_o (calc_row),
        .oob_o      (calc_oob)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        retry_d         = retry_q;
        try_dir_d       = try_dir_q;
        tgt_col_d       = tgt_col_q;
        tgt_row_d       = tgt_row_q;
        oob_d           = oob_q;
        wall_rd_d       = 1'b0;
        done_d          = 1'b0;
        collision_d     = 1'b0;
        player_col_d    = player_col_q;
        player_row_d    = player_row_q;
        player_dir_d    = player_dir_q;
        pend_valid_d    = pend_valid_q;
        pend_dir_d      = pend_dir_q;
        ghost_col_d     = ghost_col_q;
        ghost_row_d     = ghost_row_q;
        ghost_dir_d     = ghost_dir_q;
        ghost_blocked_d = ghost_blocked_q;

        unique case (state_q)
            ST_REQ: state_d = ST_CHECK;
            ST_CHECK: begin
                if (idx_q == 3'd0) begin
                    if (!blocked) begin
                        player_col_d = tgt_col_q;
                        player_row_d = tgt_row_q;
                        player_dir_d = try_dir_q;
                        if (pend_valid_q && pend_dir_q == try_dir_q) pend_valid_d = 1'b0;
                    end
                end else begin
                    if (!blocked) begin
                        ghost_col_d[cur_gi] = tgt_col_q;
                        ghost_row_d[cur_gi] = tgt_row_q;
                        ghost_dir_d[cur_gi] = try_dir_q;
                    end
                    ghost_blocked_d[cur_gi] = blocked;
                end
                if (!load) state_d = ST_COLLIDE;
            end
            ST_COLLIDE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (ghost_col_q[i] == player_col_q && ghost_row_q[i] == player_row_q) begin
                        collision_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (load) begin
            state_d   = ST_REQ;
            idx_d     = sel_idx;
            retry_d   = sel_retry;
            try_dir_d = sel_dir;
            tgt_col_d = calc_col;
            tgt_row_d = calc_row;
            oob_d     = calc_oob;
            wall_rd_d = !calc_oob;
        end

        // A request landing in the same cycle as a clear must survive.
        if (player_req_valid_i) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = player_req_dir_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            idx_q           <= 3'd0;
            retry_q         <= 1'b0;
            try_dir_q       <= DIR_UP;
            tgt_col_q       <= '0;
            tgt_row_q       <= '0;
            oob_q           <= 1'b0;
            wall_rd_q       <= 1'b0;
            player_col_q    <= COL_W'(PLAYER_SPAWN_COL);
            player_row_q    <= ROW_W'(PLAYER_SPAWN_ROW);
            player_dir_q    <= DIR_LEFT;
            pend_valid_q    <= 1'b0;
            pend_dir_q      <= DIR_UP;
            for (int i = 0; i < 4; i++) begin
                ghost_col_q[i] <= COL_W'(GHOST_SPAWN_COL[i]);
                ghost_row_q[i] <= ROW_W'(GHOST_SPAWN_ROW[i]);
                ghost_dir_q[i] <= DIR_UP;
            end
            ghost_blocked_q <= 4'b0000;
            done_q          <= 1'b0;
            collision_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            retry_q         <= retry_d;
            try_dir_q       <= try_dir_d;
            tgt_col_q       <= tgt_col_d;
            tgt_row_q       <= tgt_row_d;
            oob_q           <= oob_d;
            wall_rd_q       <= wall_rd_d;
            player_col_q    <= player_col_d;
            player_row_q    <= player_row_d;
            player_dir_q    <= player_dir_d;
            pend_valid_q    <= pend_valid_d;
            pend_dir_q      <= pend_dir_d;
            ghost_col_q     <= ghost_col_d;
            ghost_row_q     <= ghost_row_d;
            ghost_dir_q     <= ghost_dir_d;
            ghost_blocked_q <= ghost_blocked_d;
            done_q          <= done_d;
            collision_q     <= collision_d;
        end
    end

    assign wall_rd_o       = wall_rd_q;
    assign wall_col_o      = tgt_col_q;
    assign wall_row_o      = tgt_row_q;
    assign player_col_o    = player_col_q;
    assign player_row_o    = player_row_q;
    assign player_dir_o    = player_dir_q;
    assign ghost_blocked_o = ghost_blocked_q;
    assign done_o          = done_q;
    assign collision_o     = collision_q;

    always_comb begin
        ghost_col_o = '0;
        ghost_row_o = '0;
        for (int i = 0; i < 4; i++) begin
            ghost_col_o[i*COL_W +: COL_W] = ghost_col_q[i];
            ghost_row_o[i*ROW_W +: ROW_W] = ghost_row_q[i];
        end
    end

endmodule

// File: tb/tb_character_move_scheduler.sv
// Directed bench for character_move_scheduler with a small registered wall-map model.
module tb_character_move_scheduler;

    logic        clk_i;
    logic        rst_ni;
    logic        step_i;
    logic        enable_i;
    logic        player_req_valid_i;
    logic [1:0]  player_req_dir_i;
    logic [7:0]  ghost_dir_i;
    logic        wall_rd_o;
    logic [4:0]  wall_col_o;
    logic [4:0]  wall_row_o;
    logic        wall_is_wall_i = 1'b0;
    logic [4:0]  player_col_o;
    logic [4:0]  player_row_o;
    logic [1:0]  player_dir_o;
    logic [19:0] ghost_col_o;
    logic [19:0] ghost_row_o;
    logic [3:0]  ghost_blocked_o;
    logic        busy_o;
    logic        done_o;
    logic        collision_o;
    logic        overrun_o;

    int tests  = 0;
    int failed = 0;

    logic [4:0] wcol [4];
    logic [4:0] wrow [4];
    logic       wen  [4];

    character_move_scheduler dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .step_i             (step_i),
        .enable_i           (enable_i),
        .player_req_valid_i (player_req_valid_i),
        .player_req_dir_i   (player_req_dir_i),
        .ghost_dir_i        (ghost_dir_i),
        .wall_rd_o          (wall_rd_o),
        .wall_col_o         (wall_col_o),
        .wall_row_o         (wall_row_o),
        .wall_is_wall_i     (wall_is_wall_i),
        .player_col_o       (player_col_o),
        .player_row_o       (player_row_o),
        .player_dir_o       (player_dir_o),
        .ghost_col_o        (ghost_col_o),
        .ghost_row_o        (ghost_row_o),
        .ghost_blocked_o    (ghost_blocked_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .collision_o        (collision_o),
        .overrun_o          (overrun_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic is_wall(input logic [4:0] c, input logic [4:0] r);
        logic hit = 1'b0;
        for (int i = 0; i < 4; i++) if (wen[i] && wcol[i] == c && wrow[i] == r) hit = 1'b1;
        return hit;
    endfunction

    // Wall map answers the cycle after the strobe.
    always @(posedge clk_i) wall_is_wall_i <= wall_rd_o && is_wall(wall_col_o, wall_row_o);

    task automatic do_reset;
        rst_ni = 1'b0;
        step_i = 1'b0;
        enable_i = 1'b1;
        player_req_valid_i = 1'b0;
        player_req_dir_i = 2'd0;
        ghost_dir_i = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wen[i] = 1'b0; wcol[i] = 5'd0; wrow[i] = 5'd0;
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic req(input logic [1:0] d);
        @(negedge clk_i);
        player_req_valid_i = 1'b1;
        player_req_dir_i = d;
        @(negedge clk_i);
        player_req_valid_i = 1'b0;
    endtask

    // Step in cycle 0, then observe cycles 1..20; optional extra step at cycle ov_cyc.
    task automatic run_sweep(input int ov_cyc, output int done_cyc, output int n_rd,
                             output int busy_cnt, output int coll_cnt,
                             output logic coll_at_done, output int ov_cnt);
        done_cyc = -1; n_rd = 0; busy_cnt = 0; coll_cnt = 0; coll_at_done = 1'b0; ov_cnt = 0;
        @(negedge clk_i);
        step_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            step_i = (c == ov_cyc);
            #1;
            if (wall_rd_o) n_rd++;
            if (busy_o) busy_cnt++;
            if (collision_o) coll_cnt++;
            if (overrun_o) ov_cnt++;
            if (done_o && done_cyc < 0) begin
                done_cyc = c;
                coll_at_done = collision_o;
            end
        end
        step_i = 1'b0;
    endtask

    task automatic sweeps(input int n);
        int d, r, b, cc, o;
        logic ca;
        for (int k = 0; k < n; k++) run_sweep(0, d, r, b, cc, ca, o);
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (player_col_o !== 5'd13) begin failed++; $display("FAIL reset_player_col: got %0d want 13", player_col_o); end
        tests++; if (player_row_o !== 5'd23) begin failed++; $display("FAIL reset_player_row: got %0d want 23", player_row_o); end
        tests++; if (player_dir_o !== 2'd1) begin failed++; $display("FAIL reset_player_dir: got %0d want 1", player_dir_o); end
        tests++; if (ghost_col_o !== {5'd15, 5'd13, 5'd11, 5'd13}) begin failed++; $display("FAIL reset_ghost_col: got %h", ghost_col_o); end
        tests++; if (ghost_row_o !== {5'd14, 5'd14, 5'd14, 5'd11}) begin failed++; $display("FAIL reset_ghost_row: got %h", ghost_row_o); end
        tests++; if ({wall_rd_o, busy_o, done_o, collision_o, overrun_o, ghost_blocked_o} !== 9'd0) begin
            failed++; $display("FAIL reset_flags: got %b want 0", {wall_rd_o, busy_o, done_o, collision_o, overrun_o, ghost_blocked_o});
        end
    endtask

    task automatic test_open_sweep;
        int d, r, b, cc, o;
        logic ca;
        do_reset();
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (d !== 12) begin failed++; $display("FAIL open_done_cyc: got %0d want 12", d); end
        tests++; if (r !== 5) begin failed++; $display("FAIL open_wall_rds: got %0d want 5", r); end
        tests++; if (b !== 12) begin failed++; $display("FAIL open_busy_cycles: got %0d want 12", b); end
        tests++; if ({player_col_o, player_row_o} !== {5'd12, 5'd23}) begin failed++; $display("FAIL open_player: got (%0d,%0d) want (12,23)", player_col_o, player_row_o); end
        tests++; if (ghost_row_o !== {5'd13, 5'd13, 5'd13, 5'd10}) begin failed++; $display("FAIL open_ghost_row: got %h", ghost_row_o); end
        tests++; if (ghost_blocked_o !== 4'b0000) begin failed++; $display("FAIL open_blocked: got %b want 0000", ghost_blocked_o); end
        tests++; if (cc !== 0) begin failed++; $display("FAIL open_collision: got %0d want 0", cc); end
    endtask

    task automatic test_wrap_and_edge;
        int d, r, b, cc, o;
        logic ca;
        do_reset();
        sweeps(13);
        tests++; if (player_col_o !== 5'd0) begin failed++; $display("FAIL wrap_reach_col0: got %0d want 0", player_col_o); end
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (player_col_o !== 5'd27) begin failed++; $display("FAIL wrap_left: got %0d want 27", player_col_o); end
        tests++; if (r !== 4) begin failed++; $display("FAIL edge_rd_suppressed: got %0d want 4", r); end
        tests++; if (ghost_blocked_o !== 4'b0001) begin failed++; $display("FAIL edge_g0_blocked: got %b want 0001", ghost_blocked_o); end
        tests++; if (ghost_row_o !== 20'd0) begin failed++; $display("FAIL edge_ghost_rows: got %h want 0", ghost_row_o); end
        req(2'd3);
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if ({player_col_o, player_row_o, player_dir_o} !== {5'd0, 5'd23, 2'd3}) begin
            failed++; $display("FAIL wrap_right: got (%0d,%0d,d%0d) want (0,23,d3)", player_col_o, player_row_o, player_dir_o);
        end
        tests++; if (r !== 1 || d !== 12) begin failed++; $display("FAIL edge_all_blocked_rd: got rd=%0d done=%0d want 1,12", r, d); end
        tests++; if (ghost_blocked_o !== 4'b1111) begin failed++; $display("FAIL edge_all_blocked: got %b want 1111", ghost_blocked_o); end
    endtask

    task automatic test_player_retry;
        int d, r, b, cc, o;
        logic ca;
        do_reset();
        wen[0] = 1'b1; wcol[0] = 5'd13; wrow[0] = 5'd22;
        req(2'd0);
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (d !== 14) begin failed++; $display("FAIL retry_done_cyc: got %0d want 14", d); end
        tests++; if (r !== 6) begin failed++; $display("FAIL retry_wall_rds: got %0d want 6", r); end
        tests++; if ({player_col_o, player_row_o, player_dir_o} !== {5'd12, 5'd23, 2'd1}) begin
            failed++; $display("FAIL retry_fallback: got (%0d,%0d,d%0d) want (12,23,d1)", player_col_o, player_row_o, player_dir_o);
        end
        wen[0] = 1'b0;
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if ({player_col_o, player_row_o, player_dir_o} !== {5'd12, 5'd22, 2'd0}) begin
            failed++; $display("FAIL retry_pending_kept: got (%0d,%0d,d%0d) want (12,22,d0)", player_col_o, player_row_o, player_dir_o);
        end
        tests++; if (d !== 12) begin failed++; $display("FAIL retry_second_done: got %0d want 12", d); end
    endtask

    task automatic test_ghost_blocked;
        int d, r, b, cc, o;
        logic ca;
        do_reset();
        wen[1] = 1'b1; wcol[1] = 5'd11; wrow[1] = 5'd15;
        ghost_dir_i = 8'h08;
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (ghost_blocked_o !== 4'b0010) begin failed++; $display("FAIL gblk_flag: got %b want 0010", ghost_blocked_o); end
        tests++; if (ghost_row_o !== {5'd13, 5'd13, 5'd14, 5'd10}) begin failed++; $display("FAIL gblk_rows: got %h", ghost_row_o); end
        tests++; if (ghost_col_o !== {5'd15, 5'd13, 5'd11, 5'd13}) begin failed++; $display("FAIL gblk_cols: got %h", ghost_col_o); end
        wen[1] = 1'b0;
        ghost_dir_i = 8'h00;
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (ghost_blocked_o !== 4'b0000) begin failed++; $display("FAIL gblk_clear: got %b want 0000", ghost_blocked_o); end
        tests++; if (ghost_row_o[9:5] !== 5'd13) begin failed++; $display("FAIL gblk_moves: got %0d want 13", ghost_row_o[9:5]); end
    endtask

    task automatic test_collision;
        int d, r, b, cc, o, early;
        logic ca;
        do_reset();
        req(2'd0);
        ghost_dir_i = 8'h02;
        early = 0;
        for (int k = 0; k < 5; k++) begin
            run_sweep(0, d, r, b, cc, ca, o);
            early += cc;
        end
        tests++; if (early !== 0) begin failed++; $display("FAIL coll_early: got %0d want 0", early); end
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if ({player_row_o, ghost_row_o[4:0]} !== {5'd17, 5'd17}) begin
            failed++; $display("FAIL coll_tiles: got p%0d g%0d want 17,17", player_row_o, ghost_row_o[4:0]);
        end
        tests++; if (ca !== 1'b1 || d !== 12) begin failed++; $display("FAIL coll_with_done: got coll=%0d done=%0d want 1,12", ca, d); end
        tests++; if (cc !== 1) begin failed++; $display("FAIL coll_one_cycle: got %0d want 1", cc); end
    endtask

    task automatic test_overrun_enable_reset;
        int d, r, b, cc, o, late;
        logic ca;
        do_reset();
        enable_i = 1'b0;
        run_sweep(0, d, r, b, cc, ca, o);
        tests++; if (r !== 0 || d !== -1 || b !== 0) begin failed++; $display("FAIL enable_low: got rd=%0d done=%0d busy=%0d want 0,-1,0", r, d, b); end
        enable_i = 1'b1;
        run_sweep(5, d, r, b, cc, ca, o);
        tests++; if (o !== 1) begin failed++; $display("FAIL overrun_pulse: got %0d want 1", o); end
        tests++; if (d !== 12 || r !== 5) begin failed++; $display("FAIL overrun_timing: got done=%0d rd=%0d want 12,5", d, r); end
        @(negedge clk_i);
        step_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            step_i = 1'b0;
        end
        #1;
        tests++; if (player_col_o !== 5'd11) begin failed++; $display("FAIL midsweep_commit: got %0d want 11", player_col_o); end
        rst_ni = 1'b0;
        #1;
        tests++; if (busy_o !== 1'b0 || wall_rd_o !== 1'b0 || done_o !== 1'b0) begin
            failed++; $display("FAIL midreset_flags: got busy=%0d rd=%0d done=%0d want 0", busy_o, wall_rd_o, done_o);
        end
        tests++; if ({player_col_o, player_row_o, player_dir_o} !== {5'd13, 5'd23, 2'd1}) begin
            failed++; $display("FAIL midreset_player: got (%0d,%0d,d%0d) want (13,23,d1)", player_col_o, player_row_o, player_dir_o);
        end
        tests++; if (ghost_row_o !== {5'd14, 5'd14, 5'd14, 5'd11}) begin failed++; $display("FAIL midreset_ghosts: got %h", ghost_row_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        late = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (done_o || wall_rd_o || busy_o) late++;
        end
        tests++; if (late !== 0) begin failed++; $display("FAIL midreset_no_resume: got %0d active cycles want 0", late); end
    endtask

    initial begin
        test_reset();
        test_open_sweep();
        test_wrap_and_edge();
        test_player_retry();
        test_ghost_blocked();
        test_collision();
        test_overrun_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/character_move_scheduler.md
# character_move_scheduler

Sequences one movement step per game tick for the player and the four ghosts, sharing the single wall-tilemap read port between the five characters in fixed order. It holds all character tile positions and facing directions, applies wall blocking, horizontal tunnel wrap and buffered player turns, and flags player/ghost collisions. It sits between the 5 Hz character clock domain logic, the keyboard (w/a/s/d) decode and the Renderer, on the 25 MHz clock.

## Interface
- TILE_COLS, 28, maze width in tiles
- TILE_ROWS, 31, maze height in tiles
- COL_W, 5, column coordinate width
- ROW_W, 5, row coordinate width

- clk  in  1  system clock (25 MHz); one clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- step  in  1  one-cycle pulse, start of a movement sweep
- enable  in  1  game running; step ignored when low
- player_req_valid  in  1  new requested direction this cycle
- player_req_dir  in  2  requested direction (0 up, 1 left, 2 down, 3 right)
- ghost_dir  in  8  ghost n desired direction at [2n+1:2n], n=0..3
- wall_rd  out  1  wall lookup strobe
- wall_col  out  COL_W  lookup column
- wall_row  out  ROW_W  lookup row
- wall_is_wall  in  1  lookup result, valid the cycle after wall_rd
- player_col / player_row  out  COL_W / ROW_W  player tile
- player_dir  out  2  player facing
- ghost_col  out  4*COL_W  ghost columns, packed as ghost_dir
- ghost_row  out  4*ROW_W  ghost rows
- ghost_blocked  out  4  ghost n did not move in last sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep finished
- collision  out  1  one-cycle pulse with done, player shares a tile with any ghost
- overrun  out  1  one-cycle pulse, step arrived while busy

## Operation
- Reset values: player (13,23) dir left; ghosts (13,11),(11,14),(13,14),(15,14) dir up; pending turn = none; ghost_blocked 0; wall_rd, busy, done, collision, overrun 0; FSM IDLE.
- Pending turn: any cycle with player_req_valid latches player_req_dir as pending (overwrites). Cleared only when the player successfully moves in the pending direction.
- FSM: IDLE -> REQ (idx=0) on step & enable. REQ: wall_rd=1 with target tile of character idx. CHECK: sample wall_is_wall; commit or retry; idx++. After idx 4 CHECK -> COLLIDE -> IDLE.
- Player (idx 0): first try pending direction if set, else current dir. If pending try is blocked and pending != current, go REQ again with current dir (retry once). Successful pending move sets player_dir = pending. Blocked current move: player stays, dir unchanged.
- Ghost n (idx n+1): try ghost_dir[n] sampled in its REQ cycle; moves and takes that dir if clear, else stays, dir unchanged, ghost_blocked[n]=1 (cleared on a successful move).
- Target arithmetic: left from col 0 wraps to TILE_COLS-1, right from TILE_COLS-1 wraps to 0. Up from row 0 or down from TILE_ROWS-1 is blocked: wall_rd suppressed in REQ, CHECK treats as wall; cycle count unchanged.
- COLLIDE: collision=1 and done=1 for one cycle if player tile equals any committed ghost tile; only same-tile check, no pass-through detection.
- step while busy: ignored, overrun pulses that cycle. enable falling mid-sweep: sweep completes.
- Reset mid-sweep: immediate return to reset values; no partial commit.

## Timing
- step at cycle 0 -> first wall_rd cycle 1; each character 2 cycles (REQ, CHECK); player retry adds 2.
- done at cycle 12 (no retry) or 14 (retry); busy high from cycle 1 through the done cycle.
- Position outputs update in the character's CHECK cycle; Renderer sees stable values between done and next step.
- wall_col/wall_row are registered and stable while wall_rd is high.

## Structure
- Shared package/define file: direction encoding (DIR_UP..DIR_RIGHT), reset spawn tiles, TILE_COLS/TILE_ROWS defaults, FSM state codes.
- One sub-module: tile_step_calc — combinational (col,row,dir) -> (next_col,next_row,out_of_bounds) with wrap; used for all characters.

## Test plan
- Reset, open maze (wall_is_wall=0), step -> done at cycle 12, player (12,23), ghosts rows 10/13/13/13, ghost_blocked 0.
- Player at (0,14) dir left, open -> player_col=27 after sweep; at (27,14) dir right -> col 0.
- Pending up with wall above, current left clear -> two player lookups, done at cycle 14, player moves left, pending kept; next sweep wall cleared -> moves up, player_dir=0, pending cleared.
- Ghost 2 desired down into wall -> ghost2 position unchanged, ghost_blocked=4'b0010; ghost at row 0 dir up -> no wall_rd for it, blocked.
- Player and ghost1 placed to end on same tile -> collision and done both high same cycle, one cycle only.
- Second step at cycle 5 -> overrun pulse, sweep timing unchanged; reset asserted at cycle 6 -> all outputs at reset values immediately, busy 0.
